div_operand_issue: RTL and testbench
====================================

Name: div_operand_issue

Overview:
- Upstream issue stage for the pipelined divider (28-bit dividend, 20-bit divisor, 8-bit quotient).
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Classifies each pair as normal, divide-by-zero or quotient-overflow, then drives the divider's start, divided and divisor inputs one operation per cycle under downstream issue enable.
- Exceptional operations are sanitised and tagged so the divider pipeline never sees illegal operands.

Parameters:
- DIVIDEND_W, 28, dividend width
- DIVISOR_W, 20, divisor width
- Q_W, 8, quotient width of the divider; used for the overflow check
- DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept
- in_divided  in  DIVIDEND_W  dividend
- in_divisor  in  DIVISOR_W  divisor
- issue_en  in  1  downstream permits issue this cycle (result-buffer credit)
- start  out  1  one-cycle strobe to divider: operands valid
- divided  out  DIVIDEND_W  dividend to divider
- divisor  out  DIVISOR_W  divisor to divider
- exc_code  out  2  00 none, 01 divide-by-zero, 10 overflow; qualified by start
- issued_count  out  16  total operations issued, wraps
- exc_count  out  8  exceptional operations issued, saturating at 255

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: start=0, divided=0, divisor=0, exc_code=0, issued_count=0, exc_count=0, FIFO empty. in_ready=0 while reset is high.
- Accept:
  - in_ready = (count != DEPTH) && !reset, combinational.
  - A push occurs on a rising edge where in_valid && in_ready.
  - No same-cycle bypass when full.
- Classification is done at push time and stored with the entry:
  - Divide-by-zero: in_divisor == 0.
  - Overflow: (in_divided >> Q_W) >= in_divisor, i.e. the quotient does not fit in Q_W bits.
  - Divide-by-zero takes precedence over overflow.
  - Zero-extend operands for the comparison.
- Sanitising: exceptional entries are stored with divided=0 and divisor=1. Normal entries are stored unmodified.
- Issue:
  - On each rising edge with FIFO non-empty and issue_en=1, pop the head and register start=1 with divided, divisor and exc_code from that entry.
  - Otherwise start=0, and divided/divisor/exc_code hold their last values.
- Latency: a pair pushed at edge k into an empty FIFO appears with start=1 after edge k+1, provided issue_en was high at k+1. Steady-state throughput is 1 op/cycle.
- Simultaneous push and pop: allowed in the same edge when not full. count is unchanged. Pointers wrap modulo DEPTH.
- Empty with issue_en=1: start=0 and nothing is popped.
- issued_count increments on every issue. exc_count increments on every issue with exc_code != 0, saturating at 255.
- Reset mid-operation:
  - The FIFO and pointers clear immediately.
  - Pending entries are discarded and start drops asynchronously.
  - No partial issue occurs after reset releases.
- Order: operations issue strictly in acceptance order, including exceptional ones, so downstream result matching stays in order.

Decomposition:
- Shared package div_pkg holds:
  - width constants DIVIDEND_W=28, DIVISOR_W=20, Q_W=8
  - exception codes EXC_NONE=2'b00, EXC_DIV0=2'b01, EXC_OVF=2'b10
- One natural sub-module: div_issue_fifo, a parameterised sync FIFO with count, full, empty, push and pop. It carries DIVIDEND_W+DIVISOR_W+2 bits per entry.
- Classification, sanitising, issue register and counters live in the top module.

Test Plan:
- Normal op: push 100/5 with issue_en=1 → one cycle later start=1, divided=100, divisor=5, exc_code=00; issued_count=1.
- Divide-by-zero: push 21/0 → start=1, divided=0, divisor=1, exc_code=01; exc_count=1.
- Overflow boundary:
  - push 300/1 → exc_code=10, divided=0, divisor=1.
  - push 255/1 → exc_code=00, divided=255.
  - push 256/2 → exc_code=00.
- Back-pressure:
  - With issue_en=0, push 101/5, 21/3, 300/3, 40/8 → all accepted and in_ready drops to 0. A fifth push is held.
  - Raise issue_en → four consecutive start pulses in order, then in_ready=1.
  - Simultaneous push/pop at count=2 leaves count=2.
- Reset mid-stream: fill 3 entries, assert reset for 2 cycles → start=0 immediately. After release, start stays 0 with no further issues, and both counters are 0.
- Wrap and saturation: stream 300 ops with divisor 0 → issue order preserved across pointer wrap, exc_count saturates at 255, issued_count=300.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared widths and exception codes for the divider issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIVIDEND_W  = 28;
    localparam int DIVISOR_W   = 20;
    localparam int Q_W         = 8;

    localparam int EXC_W       = 2;
    localparam int ISSUE_CNT_W = 16;
    localparam int EXC_CNT_W   = 8;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE = 2'b00,
        EXC_DIV0 = 2'b01,
        EXC_OVF  = 2'b10
    } exc_code_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_operand_issue_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_operand_issue_if
//  Purpose  : Operand handshake and divider issue bus. The master side feeds
//             operands and issue credit; the slave side is the issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface div_operand_issue_if #(
    parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = div_pkg::DIVISOR_W
);
    import div_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DIVIDEND_W-1:0]  in_divided;
    logic [DIVISOR_W-1:0]   in_divisor;
    logic                   issue_en;
    logic                   start;
    logic [DIVIDEND_W-1:0]  divided;
    logic [DIVISOR_W-1:0]   divisor;
    logic [EXC_W-1:0]       exc_code;
    logic [ISSUE_CNT_W-1:0] issued_count;
    logic [EXC_CNT_W-1:0]   exc_count;

    modport master (
        output in_valid, in_divided, in_divisor, issue_en,
        input  in_ready, start, divided, divisor, exc_code,
               issued_count, exc_count
    );

    modport slave (
        input  in_valid, in_divided, in_divisor, issue_en,
        output in_ready, start, divided, divisor, exc_code,
               issued_count, exc_count
    );

endinterface : div_operand_issue_if
`default_nettype wire

// File: rtl/div_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : div_issue_fifo
//  Purpose  : Small synchronous FIFO holding classified operand entries.
//             Push is ignored when full, pop is ignored when empty.
//  Revision : 1.0 - initial release
// ============================================================================
module div_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_wdata,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because occupancy gates reads
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : div_issue_fifo
`default_nettype wire

// File: rtl/div_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module   : div_operand_issue
//  Purpose  : Accepts operand pairs, classifies them (normal / divide-by-zero
//             / quotient overflow), sanitises exceptional ones and issues one
//             operation per cycle to the pipelined divider in arrival order.
//  Revision : 1.0 - initial release
// ============================================================================
module div_operand_issue #(
    parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = div_pkg::DIVISOR_W,
    parameter int Q_W        = div_pkg::Q_W,
    parameter int DEPTH      = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    div_operand_issue_if.slave bus
);
    import div_pkg::*;

    localparam int ENTRY_W = DIVIDEND_W + DIVISOR_W + EXC_W;
    localparam int CMP_W   = (DIVIDEND_W > DIVISOR_W) ? DIVIDEND_W : DIVISOR_W;

    // Classification datapath (operands zero-extended to a common width)
    logic [CMP_W-1:0]      w_div_hi;
    logic [CMP_W-1:0]      w_dvs_ext;
    exc_code_t             w_code;
    logic [ENTRY_W-1:0]    w_entry;

    // FIFO interface
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [ENTRY_W-1:0]    w_head;
    logic [DIVIDEND_W-1:0] w_head_divided;
    logic [DIVISOR_W-1:0]  w_head_divisor;
    logic [EXC_W-1:0]      w_head_code;

    // Issue registers and counters
    logic                   r_start;
    logic [DIVIDEND_W-1:0]  r_divided;
    logic [DIVISOR_W-1:0]   r_divisor;
    logic [EXC_W-1:0]       r_exc_code;
    logic [ISSUE_CNT_W-1:0] r_issued_count;
    logic [EXC_CNT_W-1:0]   r_exc_count;

    assign w_div_hi  = CMP_W'(bus.in_divided) >> Q_W;
    assign w_dvs_ext = CMP_W'(bus.in_divisor);

    // Classify at push time; a zero divisor outranks overflow and exceptional
    // entries carry 0/1 so the divider never sees illegal operands
    always_comb begin
        w_code = EXC_NONE;
        if (w_dvs_ext == '0) begin
            w_code = EXC_DIV0;
        end else if (w_div_hi >= w_dvs_ext) begin
            w_code = EXC_OVF;
        end
        if (w_code == EXC_NONE) begin
            w_entry = {bus.in_divided, bus.in_divisor, w_code};
        end else begin
            w_entry = {DIVIDEND_W'(0), DIVISOR_W'(1), w_code};
        end
    end

    // No bypass: a full FIFO refuses input even if it pops this cycle
    assign bus.in_ready = !w_full && !reset;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = !w_empty && bus.issue_en;

    div_issue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_divided = w_head[ENTRY_W-1 -: DIVIDEND_W];
    assign w_head_divisor = w_head[EXC_W +: DIVISOR_W];
    assign w_head_code    = w_head[EXC_W-1:0];

    // Issue register: strobe start for one cycle, operands hold otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start    <= 1'b0;
            r_divided  <= '0;
            r_divisor  <= '0;
            r_exc_code <= '0;
        end else if (w_pop) begin
            r_start    <= 1'b1;
            r_divided  <= w_head_divided;
            r_divisor  <= w_head_divisor;
            r_exc_code <= w_head_code;
        end else begin
            r_start    <= 1'b0;
        end
    end

    // Issue counter wraps; exception counter saturates at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issued_count <= '0;
            r_exc_count    <= '0;
        end else if (w_pop) begin
            r_issued_count <= r_issued_count + ISSUE_CNT_W'(1);
            if ((w_head_code != EXC_NONE) && (r_exc_count != '1)) begin
                r_exc_count <= r_exc_count + EXC_CNT_W'(1);
            end
        end
    end

    assign bus.start        = r_start;
    assign bus.divided      = r_divided;
    assign bus.divisor      = r_divisor;
    assign bus.exc_code     = r_exc_code;
    assign bus.issued_count = r_issued_count;
    assign bus.exc_count    = r_exc_count;

endmodule : div_operand_issue
`default_nettype wire

// File: tb/tb_div_operand_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_operand_issue
//  Purpose  : Self-checking bench for div_operand_issue with a queue-based
//             reference model, directed cases and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_operand_issue;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    div_operand_issue_if bus ();

    div_operand_issue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned c;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_start, m_divd, m_dvs, m_code, m_iss, m_exc;
    int unsigned m_pushes;
    int          n_vec = 0;
    int          n_err = 0;

    // Reference classification: quotient must fit in 8 bits
    function automatic int unsigned klass(int unsigned a, int unsigned b);
        if (b == 0) return 1;
        if ((a / b) >= 256) return 2;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mclear();
        mq.delete();
        m_start = 0; m_divd = 0; m_dvs = 0; m_code = 0; m_iss = 0; m_exc = 0;
    endtask

    // One clock: compare at negedge, advance the model, return just after posedge
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e;
        @(negedge clock);
        if (reset) mclear();
        chk("in_ready",     bus.in_ready, ((mq.size() != DEPTH) && !reset) ? 1 : 0);
        chk("start",        bus.start, m_start);
        chk("divided",      bus.divided, m_divd);
        chk("divisor",      bus.divisor, m_dvs);
        chk("exc_code",     bus.exc_code, m_code);
        chk("issued_count", bus.issued_count, m_iss);
        chk("exc_count",    bus.exc_count, m_exc);
        if (!reset) begin
            do_push = bus.in_valid && (mq.size() != DEPTH);
            do_pop  = bus.issue_en && (mq.size() != 0);
            if (do_pop) begin
                e       = mq.pop_front();
                m_start = 1; m_divd = e.a; m_dvs = e.b; m_code = e.c;
                m_iss   = (m_iss + 1) & 32'hFFFF;
                if (e.c != 0 && m_exc != 255) m_exc++;
            end else begin
                m_start = 0;
            end
            if (do_push) begin
                e.a = bus.in_divided;
                e.b = bus.in_divisor;
                e.c = klass(e.a, e.b);
                if (e.c != 0) begin
                    e.a = 0;
                    e.b = 1;
                end
                mq.push_back(e);
                m_pushes++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit v, input int unsigned a, input int unsigned b);
        bus.in_valid   = v;
        bus.in_divided = a[27:0];
        bus.in_divisor = b[19:0];
    endtask

    // Push one pair with issue enabled, then idle one cycle so it issues
    task automatic op(input int unsigned a, input int unsigned b);
        bus.issue_en = 1'b1;
        drive(1'b1, a, b);
        cycle();
        drive(1'b0, 0, 0);
        cycle();
    endtask

    initial begin
        int unsigned bp_a[4];
        int unsigned a, b, r;
        bp_a = '{101, 21, 300, 40};
        mclear();
        m_pushes     = 0;
        bus.issue_en = 1'b0;
        drive(1'b0, 0, 0);
        @(posedge clock);
        #1;
        cycle();
        cycle();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_start",    bus.start, 0);
        chk("rst_issued",   bus.issued_count, 0);
        reset = 1'b0;
        cycle();

        // Normal op and exceptional classes with literal expectations
        op(100, 5);
        chk("norm_start", bus.start, 1);
        chk("norm_divd",  bus.divided, 100);
        chk("norm_dvs",   bus.divisor, 5);
        chk("norm_code",  bus.exc_code, 0);
        chk("norm_iss",   bus.issued_count, 1);
        op(21, 0);
        chk("div0_start", bus.start, 1);
        chk("div0_divd",  bus.divided, 0);
        chk("div0_dvs",   bus.divisor, 1);
        chk("div0_code",  bus.exc_code, 1);
        chk("div0_exc",   bus.exc_count, 1);
        op(300, 1);
        chk("ovf_code",   bus.exc_code, 2);
        chk("ovf_divd",   bus.divided, 0);
        chk("ovf_dvs",    bus.divisor, 1);
        op(255, 1);
        chk("b255_code",  bus.exc_code, 0);
        chk("b255_divd",  bus.divided, 255);
        op(256, 2);
        chk("b256_code",  bus.exc_code, 0);
        chk("b256_divd",  bus.divided, 256);

        // Back-pressure: fill with issue disabled, try a fifth push
        bus.issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, bp_a[i], (i == 0) ? 5 : (i == 1) ? 3 : (i == 2) ? 3 : 8);
            cycle();
        end
        chk("bp_full_ready", bus.in_ready, 0);
        drive(1'b1, 7, 1);
        cycle();
        chk("bp_held_ready", bus.in_ready, 0);
        drive(1'b0, 0, 0);
        bus.issue_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_start", bus.start, 1);
            chk("bp_order", bus.divided, bp_a[i]);
        end
        chk("bp_ready_after", bus.in_ready, 1);
        cycle();
        chk("bp_idle_start", bus.start, 0);

        // Simultaneous push/pop at two entries keeps occupancy at two
        bus.issue_en = 1'b0;
        drive(1'b1, 11, 1); cycle();
        drive(1'b1, 12, 1); cycle();
        bus.issue_en = 1'b1;
        drive(1'b1, 13, 1); cycle();
        chk("simul_model_cnt", mq.size(), 2);
        chk("simul_divd", bus.divided, 11);
        drive(1'b0, 0, 0);
        repeat (3) cycle();

        // Randomized traffic mixing all classes and back-pressure
        for (int i = 0; i < 1500; i++) begin
            r = $urandom % 8;
            if (r == 0)      b = 0;
            else if (r < 3)  b = $urandom_range(1, 4);
            else             b = $urandom & 32'hFFFFF;
            r = $urandom % 4;
            if (r == 0)      a = $urandom_range(0, 2047);
            else if (r == 1) a = b * 256 + $urandom_range(0, 2) - 1;
            else             a = $urandom & 32'hFFFFFFF;
            drive(($urandom % 4) != 0, a, b);
            bus.issue_en = (($urandom % 3) != 0);
            cycle();
        end
        drive(1'b0, 0, 0);
        bus.issue_en = 1'b1;
        repeat (6) cycle();

        // Reset mid-stream with entries pending and a live start
        bus.issue_en = 1'b0;
        drive(1'b1, 31, 1); cycle();
        drive(1'b1, 32, 1); cycle();
        drive(1'b1, 33, 1); cycle();
        drive(1'b0, 0, 0);
        bus.issue_en = 1'b1;
        cycle();
        chk("pre_rst_start", bus.start, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_start", bus.start, 0);
        chk("rst_async_ready", bus.in_ready, 0);
        mclear();
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_start", bus.start, 0);
        end
        chk("post_rst_iss", bus.issued_count, 0);
        chk("post_rst_exc", bus.exc_count, 0);

        // 300 divide-by-zero ops: wrap the pointers and saturate exc_count
        m_pushes = 0;
        bus.issue_en = 1'b1;
        for (int i = 0; i < 2000 && m_pushes < 300; i++) begin
            drive(1'b1, $urandom & 32'hFFFFFFF, 0);
            cycle();
        end
        drive(1'b0, 0, 0);
        repeat (4) cycle();
        chk("sat_pushes", m_pushes, 300);
        chk("sat_exc",    bus.exc_count, 255);
        chk("sat_iss",    bus.issued_count, 300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_div_operand_issue
`default_nettype wire
